bios_loader: RTL

Download-side write sequencer in front of the `bios` (64 KiB) and `xtide` (16 KiB) byte RAMs. Accepts 16-bit words from the HPS ioctl download channel, splits each into two byte writes on the RAM write ports (`ena`/`wea`/`addra`/`dina`), and routes them by download index. It holds the CPU in reset from the start of a download until the last byte has landed.

---
 rtl/pcxt_loader_pkg.sv | 26 ++
 rtl/bios_loader_route.sv | 28 ++
 rtl/bios_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pcxt_loader_pkg.sv
// Shared types and constants for the PC/XT ROM download sequencer.
package pcxt_loader_pkg;

  // Write sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WLO   = 2'd1,
    WHI   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // RAM selected for the word being written
  typedef enum logic [1:0] {
    TGT_NONE  = 2'd0,
    TGT_BIOS  = 2'd1,
    TGT_XTIDE = 2'd2
  } target_t;

  localparam logic [7:0] BIOS_INDEX_DEF  = 8'd0;
  localparam logic [7:0] XTIDE_INDEX_DEF = 8'd1;

  // First byte address beyond each RAM
  localparam logic [23:0] BIOS_LIMIT  = 24'h010000;
  localparam logic [23:0] XTIDE_LIMIT = 24'h004000;

endpackage

// File: rtl/bios_loader_route.sv
// Combinational decoder: maps the ioctl index to a target RAM and checks
// that the word address lies inside that RAM.
module bios_loader_route
  import pcxt_loader_pkg::*;
#(
  parameter logic [7:0] BIOS_INDEX  = BIOS_INDEX_DEF,
  parameter logic [7:0] XTIDE_INDEX = XTIDE_INDEX_DEF
) (
  input  logic [7:0]  index,
  input  logic [23:0] addr,
  output target_t     target,
  output logic        in_range
);

  // Unknown indices decode to no target but are not an error
  always_comb begin
    target   = TGT_NONE;
    in_range = 1'b1;
    if (index == BIOS_INDEX) begin
      target   = TGT_BIOS;
      in_range = (addr < BIOS_LIMIT);
    end else if (index == XTIDE_INDEX) begin
      target   = TGT_XTIDE;
      in_range = (addr < XTIDE_LIMIT);
    end
  end

endmodule

// File: rtl/bios_loader.sv
// Download write sequencer for the BIOS and XTIDE byte RAMs. Each 16-bit
// ioctl word becomes a low-byte write then a high-byte write; the CPU is
// held in reset while a download is in progress.
// Optional feature macro: BIOS_LOADER_CHECKSUM_EN adds an 8-bit byte sum
// output of everything written during the current download.
module bios_loader
  import pcxt_loader_pkg::*;
#(
  parameter logic [7:0] BIOS_INDEX  = BIOS_INDEX_DEF,
  parameter logic [7:0] XTIDE_INDEX = XTIDE_INDEX_DEF
) (
  input  logic        clka,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [23:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  output logic        bios_ena,
  output logic        bios_wea,
  output logic [15:0] bios_addra,
  output logic [7:0]  bios_dina,
  output logic        xtide_ena,
  output logic        xtide_wea,
  output logic [13:0] xtide_addra,
  output logic [7:0]  xtide_dina,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        err
`ifdef BIOS_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  state_t      state_reg, state_next;
  target_t     route_target, sel_reg;
  logic        route_in_range;
  logic [15:1] addr_reg;
  logic [15:0] data_reg;
  logic        download_reg, wait_reg, hold_reg, done_reg, err_reg;
  logic        rise, busy, accept;
  logic        wr_bios, wr_xtide, wr_hi;
  logic [15:0] wr_addr;
  logic [7:0]  wr_byte;

  assign rise   = ioctl_download & ~download_reg;
  assign busy   = (state_reg == WLO) || (state_reg == WHI);
  assign accept = (state_reg == IDLE) && ioctl_download && ioctl_wr;

  bios_loader_route #(
    .BIOS_INDEX  (BIOS_INDEX),
    .XTIDE_INDEX (XTIDE_INDEX)
  ) u_route (
    .index    (ioctl_index),
    .addr     (ioctl_addr),
    .target   (route_target),
    .in_range (route_in_range)
  );

  // State register
  always_ff @(posedge clka) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next state: a word always runs WLO then WHI; DRAIN covers a word that
  // finished after the download window had already closed
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WLO;
      WLO:     state_next = WHI;
      WHI:     state_next = ioctl_download ? IDLE : DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: strobes follow the state, payload comes from the latch
  always_comb begin
    wr_hi    = (state_reg == WHI);
    wr_bios  = busy && (sel_reg == TGT_BIOS);
    wr_xtide = busy && (sel_reg == TGT_XTIDE);
    wr_addr  = {addr_reg, wr_hi};
    wr_byte  = wr_hi ? data_reg[15:8] : data_reg[7:0];
  end

  assign bios_ena    = wr_bios;
  assign bios_wea    = wr_bios;
  assign bios_addra  = wr_addr;
  assign bios_dina   = wr_byte;
  assign xtide_ena   = wr_xtide;
  assign xtide_wea   = wr_xtide;
  assign xtide_addra = wr_addr[13:0];
  assign xtide_dina  = wr_byte;
  assign ioctl_wait  = wait_reg;
  assign cpu_hold    = hold_reg;
  assign load_done   = done_reg;
  assign err         = err_reg;

  // Word latch; an out-of-range word is latched with no target so the
  // sequencer still takes its three cycles but writes nothing
  always_ff @(posedge clka) begin
    if (!reset_n) begin
      addr_reg <= '0;
      data_reg <= '0;
      sel_reg  <= TGT_NONE;
    end else if (accept) begin
      addr_reg <= ioctl_addr[15:1];
      data_reg <= ioctl_dout;
      sel_reg  <= route_in_range ? route_target : TGT_NONE;
    end
  end

  // Handshake and status flags; a new error in the same cycle as the
  // download start takes priority over the clear
  always_ff @(posedge clka) begin
    if (!reset_n) begin
      download_reg <= 1'b0;
      wait_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      download_reg <= ioctl_download;
      wait_reg     <= (state_next == WLO) || (state_next == WHI);
      done_reg     <= 1'b0;
      if (rise) begin
        hold_reg <= 1'b1;
      end else if (hold_reg && (state_reg == IDLE) && !ioctl_download) begin
        hold_reg <= 1'b0;
        done_reg <= 1'b1;
      end
      if (rise) err_reg <= 1'b0;
      if ((accept && !route_in_range) || (ioctl_wr && busy)) err_reg <= 1'b1;
    end
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg;

  // Running mod-256 sum of bytes that actually reached a RAM
  always_ff @(posedge clka) begin
    if (!reset_n)                checksum_reg <= '0;
    else if (rise)               checksum_reg <= '0;
    else if (wr_bios || wr_xtide) checksum_reg <= checksum_reg + wr_byte;
  end

  assign checksum = checksum_reg;
`else
  // No checksum accumulator in this build.
`endif

endmodule
